td4_sequencer: RTL
==================

# td4_sequencer

Instruction sequencer for the TD4 4-bit CPU. It owns the program counter, fetches one 8-bit instruction per step from the combinational 16x8 program ROM, decodes it and executes it in the same cycle. It holds registers A and B, the carry flag and the output port. It sits between the ROM (which it addresses) and the board I/O (4-bit input switches, 4-bit LED output).

## Interface
- No parameters. Widths are fixed by the TD4 ISA: 4-bit data, 4-bit address, 8-bit instruction.
- Clock and reset: one clock, `CLK`. Reset is `RESET`, synchronous and active-high.
- `CLK` input, 1 bit: rising-edge clock.
- `RESET` input, 1 bit: synchronous, active-high; has priority over `STEP_EN`.
- `STEP_EN` input, 1 bit: when high, execute one instruction on this edge; when low, hold all state.
- `ROM_ADDR` output, 4 bits: equal to the PC; drives the ROM address.
- `ROM_DATA` input, 8 bits: instruction from the ROM. Opcode is [7:4], immediate Im is [3:0].
- `IN_PORT` input, 4 bits: input switches, sampled at the executing edge.
- `OUT_PORT` output, 4 bits: registered LED output.
- `CARRY` output, 1 bit: carry flag.
- `REG_A` output, 4 bits: register A, for observation.
- `REG_B` output, 4 bits: register B, for observation.

## Operation
Opcode decode (`ROM_DATA[7:4]`):
- 0000 ADD A,Im: A = A+Im; C = carry-out.
- 0001 MOV A,B: A = B.
- 0010 IN A: A = IN_PORT.
- 0011 MOV A,Im: A = Im.
- 0100 MOV B,A: B = A.
- 0101 ADD B,Im: B = B+Im; C = carry-out.
- 0110 IN B: B = IN_PORT.
- 0111 MOV B,Im: B = Im.
- 1001 OUT B: OUT_PORT = B.
- 1011 OUT Im: OUT_PORT = Im.
- 1110 JNC Im: PC = Im if C==0, else PC+1.
- 1111 JMP Im: PC = Im.
- 1000, 1010, 1100, 1101: NOP, PC+1.

Rules:
- Additions are 4-bit modulo 16; the carry is bit 4 of the 5-bit sum.
- Every executed non-ADD instruction clears C, including JNC, JMP and NOPs. JNC tests the C value produced by the previous instruction.
- Non-jump instructions set PC = PC+1, wrapping 15 -> 0.
- Registers not named by the instruction hold their value.
- Conceptual states: RESET and RUN. HALT exists only with the macro (see Configuration).
  - RESET -> RUN on the first edge with `RESET` low.
  - In RUN, each edge with `STEP_EN` high executes exactly one instruction.

## Timing
- Reset values: PC = 0, A = 0, B = 0, C = 0, OUT_PORT = 0. Therefore `ROM_ADDR` = 0 and `HALTED` = 0.
- Fetch and execute take a single cycle. The ROM is combinational, so `ROM_DATA` must be valid from `ROM_ADDR` within the same cycle.
- All results, including the PC, become visible the cycle after the executing edge.
- `STEP_EN` low for N cycles means no state changes for those N cycles. The instruction at PC executes on the next enabled edge.
- `RESET` high on an edge with `STEP_EN` high: reset wins and the instruction is discarded.
- Reset in mid-program returns all state to the reset values on that edge.
- `IN_PORT` is sampled only on executing edges; changes between steps are ignored.
- ADD with A=15, Im=1: A = 0 and C = 1 on the next cycle. A JNC following it falls through to PC+1.

## Configuration
- Macro: `TD4_HALT_DETECT_EN`.
- Defined:
  - Adds output `HALTED` (1 bit, reset 0).
  - Executing JMP Im with Im == current PC, or JNC Im with C==0 and Im == PC, sets `HALTED` = 1 on that edge.
  - Once `HALTED` is 1, further steps are ignored (all state frozen) until `RESET`.
  - The JMP that causes the halt still clears C.
- Not defined:
  - No `HALTED` port.
  - A self-jump re-executes every enabled cycle, with PC unchanged and C cleared.

## Test plan
- Blink program:
  - ROM = B3, B6, BC, B8, B8, BC, B6, B3, B1, F0, then 00 for the rest.
  - Hold `STEP_EN` = 1.
  - Required: `OUT_PORT` sequence 3, 6, C, 8, 8, C, 6, 3, 1, 1, then 3 again. PC wraps 9 -> 0, giving a period of 10 steps. C stays 0 throughout.
- Carry and JNC:
  - ROM = 3F (MOV A,F), 01 (ADD A,1), E0 (JNC 0), 9?, ...
  - Required: after ADD, A = 0 and C = 1. JNC falls through to PC 3, and C = 0 afterwards.
  - Repeat with ADD A,0 in place of ADD A,1: JNC jumps to 0.
- Input and stall:
  - `IN_PORT` = 5, ROM = 20 (IN A), 41 (MOV B,A), 90 (OUT B).
  - Toggle `STEP_EN` 1,0,0,1,1 and change `IN_PORT` to A while `STEP_EN` is low.
  - Required: `OUT_PORT` = 5 after the third executed step. State is unchanged during the stalled cycles.
- PC wrap:
  - ROM is all 00 (ADD A,0).
  - Required: after 16 steps, PC = 0 and A = 0.
- Reset priority:
  - Run the blink program to PC = 4, then assert `RESET` together with `STEP_EN`.
  - Required: on the next cycle PC, A, B, C and `OUT_PORT` are all 0, and the first instruction re-executes once `RESET` falls.
- With `TD4_HALT_DETECT_EN`:
  - ROM = B7 (OUT 7), F1 (JMP 1).
  - Required: `HALTED` = 1 after the 2nd step. PC holds 1 and `OUT_PORT` holds 7 for 20 further enabled cycles. `RESET` clears `HALTED`.

Source files
------------

// File: rtl/td4_sequencer.sv
// TD4 4-bit CPU sequencer: PC, fetch from combinational ROM, single-cycle decode/execute.
// Optional TD4_HALT_DETECT_EN adds a HALTED output that freezes the core on a self-jump.
module td4_sequencer (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       STEP_EN,
    output logic [3:0] ROM_ADDR,
    input  logic [7:0] ROM_DATA,
    input  logic [3:0] IN_PORT,
    output logic [3:0] OUT_PORT,
    output logic       CARRY,
    output logic [3:0] REG_A,
    output logic [3:0] REG_B
`ifdef TD4_HALT_DETECT_EN
    ,
    output logic       HALTED
`endif
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic       c_q, c_d;

    logic [3:0] opcode, im;
    logic [4:0] sum_a, sum_b;
    logic       step;

    assign opcode = ROM_DATA[7:4];
    assign im     = ROM_DATA[3:0];
    assign sum_a  = {1'b0, a_q} + {1'b0, im};
    assign sum_b  = {1'b0, b_q} + {1'b0, im};
    assign step   = STEP_EN && (state_q != ST_HALT);

    always_comb begin
        state_d = (state_q == ST_HALT) ? ST_HALT : ST_RUN;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        c_d     = c_q;
        if (step) begin
            pc_d = pc_q + 4'd1;
            c_d  = 1'b0;
            case (opcode)
                4'b0000: begin a_d = sum_a[3:0]; c_d = sum_a[4]; end
                4'b0001: a_d = b_q;
                4'b0010: a_d = IN_PORT;
                4'b0011: a_d = im;
                4'b0100: b_d = a_q;
                4'b0101: begin b_d = sum_b[3:0]; c_d = sum_b[4]; end
                4'b0110: b_d = IN_PORT;
                4'b0111: b_d = im;
                4'b1001: out_d = b_q;
                4'b1011: out_d = im;
                4'b1110: if (!c_q) pc_d = im;
                4'b1111: pc_d = im;
                default: ;
            endcase
`ifdef TD4_HALT_DETECT_EN
            // A taken jump onto itself can never make progress, so park the core.
            if ((opcode == 4'b1111 || (opcode == 4'b1110 && !c_q)) && im == pc_q)
                state_d = ST_HALT;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RESET;
            pc_q    <= 4'd0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            out_q   <= 4'd0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            c_q     <= c_d;
        end
    end

    assign ROM_ADDR = pc_q;
    assign OUT_PORT = out_q;
    assign CARRY    = c_q;
    assign REG_A    = a_q;
    assign REG_B    = b_q;
`ifdef TD4_HALT_DETECT_EN
    assign HALTED   = (state_q == ST_HALT);
`endif

endmodule
